lsu_master: RTL and testbench
=============================

// Module: lsu_master
// PURPOSE
//   Load/store initiator between the core's memory-stage request and the word-indexed data_memory
//   (combinational read, posedge write, index = A). Converts byte addresses to word indices and
//   performs sign/zero-extended sub-word loads. Handles sb/sh as read-modify-write and reports
//   misaligned, out-of-range or illegal requests. Single outstanding request.
// PARAMETERS
//   MEM_WORDS  1024  depth of attached data_memory in 32-bit words; word index >= MEM_WORDS -> error
// PORTS
//   clk        in   1   clock, all state on posedge
//   rst        in   1   reset, synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   block can accept (high only in IDLE)
//   req_we     in   1   1=store, 0=load
//   req_funct3 in   3   RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
//   rsp_valid  out  1   one-cycle pulse: request complete
//   rsp_rdata  out  32  load result, extended; 0 for stores/errors; held until next rsp_valid
//   rsp_err    out  1   qualified by rsp_valid: misaligned / out-of-range / illegal funct3
//   mem_a      out  32  word index to data_memory = {2'b00, addr[31:2]}
//   mem_we     out  1   data_memory write enable
//   mem_wd     out  32  data_memory write data
//   mem_rd     in   32  data_memory read data (combinational from mem_a)
// BEHAVIOUR
//   Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_a=0, mem_we=0, mem_wd=0.
//   req_ready = (state==IDLE) && !rst. Accept = req_valid && req_ready at edge E0; latch we/funct3/addr/wdata.
//   States: IDLE, LOAD, RMW_RD, WRITE, RESP.
//   - Error check at accept: funct3 illegal (011,110,111; or 100/101 with we=1); h-type with addr[0]!=0;
//     w with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.  Error -> RESP directly, no memory access.
//   - Load: IDLE->LOAD; at E1 capture mem_rd, select byte addr[1:0] / half addr[1], sign- (b,h) or
//     zero-extend (bu,hu, w as-is) into rsp_rdata -> RESP.
//   - sw: IDLE->WRITE; mem_wd=wdata, mem_we=1 for exactly that cycle; write at E1 -> RESP.
//   - sb/sh: IDLE->RMW_RD; at E1 capture mem_rd, merge wdata lane(s) at addr[1:0] -> WRITE; write at E2 -> RESP.
//   - RESP: rsp_valid=1 for one cycle (no backpressure), then IDLE; earliest next accept one cycle later.
//   Latency accept->rsp_valid high: error 1 cycle; lw/lh/lb/sw 2 cycles; sb/sh 3 cycles.
//   mem_a driven with latched index in LOAD/RMW_RD/WRITE, else 0. mem_wd = 0 outside WRITE.
//   mem_we = (state==WRITE) && !rst  -- reset asserted in WRITE cycle suppresses the write.
//   Reset mid-operation: any state -> IDLE next edge, no rsp_valid for the aborted request.
//   Word index never wraps: out-of-range is an error, not truncated.
// CONFIGURATION
//   LSU_STAT_EN defined: adds outputs stat_loads, stat_stores, stat_errs (16 bits each), incremented
//   on each rsp_valid by class (error counted only in stat_errs), saturating at 16'hFFFF, cleared by rst.
//   Not defined: ports and counters absent; core behaviour identical.
// TESTING
//   1. mem[4]=32'hDEADBEEF; lw addr 0x10 -> rsp_valid 2 cycles after accept, rsp_rdata 32'hDEADBEEF, err=0.
//   2. Same mem; lb 0x13 -> 32'hFFFFFFDE; lbu 0x13 -> 32'h000000DE; lh 0x12 -> 32'hFFFFDEAD; lhu 0x10 -> 32'h0000BEEF.
//   3. sb wdata 32'h12345655 addr 0x11 -> single mem_we pulse at index 4, mem[4]=32'hDEAD55EF, rsp 3 cycles.
//   4. sh 0x11, lw 0x12, lb 0x1000 (MEM_WORDS=1024), funct3=011 -> each rsp_err=1 after 1 cycle, mem_we never high.
//   5. sw 0x20 wdata 32'hA5A5A5A5 with rst high during WRITE -> mem[8] unchanged, no rsp_valid, req_ready high after.
//   6. LSU_STAT_EN: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errs=1; rst clears to 0.

Source files
------------

// File: rtl/lsu_master_if.sv
// -----------------------------------------------------------------------------
// lsu_master_if
//   Bundles the request/response handshake between the core memory stage and
//   the load/store unit, together with the word-indexed data_memory port.
//
//   Signals
//     req_valid  core -> lsu  request present
//     req_ready  lsu -> core  lsu can accept a request
//     req_we     core -> lsu  1 = store, 0 = load
//     req_funct3 core -> lsu  RV32I access size / signedness
//     req_addr   core -> lsu  byte address
//     req_wdata  core -> lsu  right-aligned store data
//     rsp_valid  lsu -> core  one-cycle completion pulse
//     rsp_rdata  lsu -> core  extended load data (0 for stores and errors)
//     rsp_err    lsu -> core  request rejected, qualified by rsp_valid
//     mem_a      lsu -> mem   word index
//     mem_we     lsu -> mem   write enable
//     mem_wd     lsu -> mem   write data
//     mem_rd     mem -> lsu   combinational read data for mem_a
//
//   Modports
//     master : the load/store unit
//     slave  : the core plus data_memory side
// -----------------------------------------------------------------------------
interface lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_master.sv
// -----------------------------------------------------------------------------
// lsu_master
//   Load/store initiator between the core memory stage and a word-indexed
//   data_memory (combinational read, posedge write). Converts byte addresses
//   to word indices, sign/zero-extends sub-word loads, performs sb/sh as a
//   read-modify-write and rejects misaligned, out-of-range or illegal
//   requests. One request is outstanding at a time.
//
//   Parameters
//     MEM_WORDS   depth of data_memory in 32-bit words; larger indices error
//
//   Ports
//     clk         clock, all state on posedge
//     rst         synchronous active-high reset
//     bus         lsu_master_if.master (request, response, memory port)
//     stat_loads  completed loads           (only with LSU_STAT_EN)
//     stat_stores completed stores          (only with LSU_STAT_EN)
//     stat_errs   rejected requests         (only with LSU_STAT_EN)
//
//   Configuration macro
//     LSU_STAT_EN  when defined, adds saturating 16-bit completion counters.
//
//   Latency accept -> rsp_valid: error 1, lw/lh/lb/sw 2, sb/sh 3 cycles.
// -----------------------------------------------------------------------------
module lsu_master #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  lsu_master_if.master  bus
`ifdef LSU_STAT_EN
  ,
  output logic [15:0]   stat_loads,
  output logic [15:0]   stat_stores,
  output logic [15:0]   stat_errs
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic [31:0] mem_a_r;
  logic        mem_we_r;
  logic [31:0] mem_wd_r;

  // Word index into data_memory; the top two bits are always zero.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Classify a request as illegal: bad funct3, misalignment, or an index
  // beyond the memory. Indices never wrap, so large addresses are rejected.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad_f3;
    logic bad_align;
    logic bad_range;
    case (f3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = we;   // unsigned variants exist only for loads
      default:          bad_f3 = 1'b1;
    endcase
    case (f3)
      F3_H, F3_HU: bad_align = addr[0];
      F3_W:        bad_align = (addr[1:0] != 2'b00);
      default:     bad_align = 1'b0;
    endcase
    bad_range = (word_index(addr) >= 32'(MEM_WORDS));
    return bad_f3 | bad_align | bad_range;
  endfunction

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    r = {old[31:8], wd[7:0]};
          2'd1:    r = {old[31:16], wd[7:0], old[7:0]};
          2'd2:    r = {old[31:24], wd[7:0], old[15:0]};
          2'd3:    r = {wd[7:0], old[23:0]};
          default: r = old;
        endcase
      end
      F3_H:    r = off[1] ? {wd[15:0], old[15:0]} : {old[31:16], wd[15:0]};
      default: r = old;
    endcase
    return r;
  endfunction

  // Control FSM; every response and memory-port output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      wdata_r     <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      mem_a_r     <= 32'd0;
      mem_we_r    <= 1'b0;
      mem_wd_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            off_r    <= bus.req_addr[1:0];
            wdata_r  <= bus.req_wdata;
            if (req_error(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              // Rejected requests never touch memory.
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'd0;
            end else if (!bus.req_we) begin
              state_r <= ST_LOAD;
              mem_a_r <= word_index(bus.req_addr);
            end else if (bus.req_funct3 == F3_W) begin
              // Full-word store needs no read, write straight away.
              state_r  <= ST_WRITE;
              mem_a_r  <= word_index(bus.req_addr);
              mem_we_r <= 1'b1;
              mem_wd_r <= bus.req_wdata;
            end else begin
              state_r <= ST_RMW_RD;
              mem_a_r <= word_index(bus.req_addr);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r     <= ST_RESP;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= load_extract(bus.mem_rd, funct3_r, off_r);
          mem_a_r     <= 32'd0;
        end
        ST_RMW_RD: begin
          // mem_a_r stays on the same index for the write-back cycle.
          state_r  <= ST_WRITE;
          mem_we_r <= 1'b1;
          mem_wd_r <= store_merge(bus.mem_rd, wdata_r, funct3_r, off_r);
        end
        ST_WRITE: begin
          state_r     <= ST_RESP;
          mem_we_r    <= 1'b0;
          mem_wd_r    <= 32'd0;
          mem_a_r     <= 32'd0;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'd0;
        end
        ST_RESP: begin
          // No backpressure: the pulse lasts exactly one cycle.
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_wd_r    <= 32'd0;
          mem_a_r     <= 32'd0;
        end
      endcase
    end
  end

  // Reset gates ready and write enable in the same cycle, so a reset that
  // lands during WRITE suppresses the memory update.
  assign bus.req_ready = (state_r == ST_IDLE) && !rst;
  assign bus.mem_we    = mem_we_r && !rst;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mem_a     = mem_a_r;
  assign bus.mem_wd    = mem_wd_r;

`ifdef LSU_STAT_EN
  logic [15:0] stat_loads_r;
  logic [15:0] stat_stores_r;
  logic [15:0] stat_errs_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Completion counters, bumped once per response by request class.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_r  <= 16'd0;
      stat_stores_r <= 16'd0;
      stat_errs_r   <= 16'd0;
    end else if (rsp_valid_r) begin
      if (rsp_err_r) begin
        stat_errs_r <= sat_inc(stat_errs_r);
      end else if (we_r) begin
        stat_stores_r <= sat_inc(stat_stores_r);
      end else begin
        stat_loads_r <= sat_inc(stat_loads_r);
      end
    end else begin
      stat_loads_r <= stat_loads_r;
    end
  end

  assign stat_loads  = stat_loads_r;
  assign stat_stores = stat_stores_r;
  assign stat_errs   = stat_errs_r;
`endif

endmodule

// File: tb/tb_lsu_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_master
//   Table of load/store vectors applied one at a time against a behavioural
//   data_memory; expected responses are queued on issue and compared when the
//   response pulse arrives. Hand-written sequences cover reset values and a
//   reset that lands in the WRITE cycle of a store.
// -----------------------------------------------------------------------------
module tb_lsu_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_master_if bus ();

`ifdef LSU_STAT_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  lsu_master #(.MEM_WORDS(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef LSU_STAT_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // Behavioural data_memory: combinational read, posedge write.
  logic [31:0] mem [0:1023];
  int          we_count = 0;
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  assign bus.mem_rd = (bus.mem_a < 32'd1024) ? mem[bus.mem_a[9:0]] : 32'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[9:0]] <= bus.mem_wd;
      we_count <= we_count + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_loads = 0;
  int   n_stores = 0;
  int   n_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = idx[9:0];
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk);
    #1;
    pl_en  = 1'b0;
  endtask

  task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                         input int lat, input int writes, input int idx, input logic [31:0] val);
    vecs.push_back('{we, f3, addr, wdata, rdata, err, lat, writes, idx, val});
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    int   w0;
    exp_t e;
    wait_ready(tag);
    w0 = we_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    if (v.exp_err) n_errs++;
    else if (v.we) n_stores++;
    else n_loads++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb_q.pop_front();
    chk({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(e.lat));
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, " rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
    @(posedge clk);
    #1;
    chk({tag, " pulse_end"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, " rdata_hold"}, bus.rsp_rdata, e.rdata);
    chk({tag, " mem_writes"}, 32'(we_count - w0), 32'(v.exp_writes));
    if (v.chk_idx >= 0) begin
      chk({tag, " mem_word"}, mem[v.chk_idx], v.chk_val);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   w0;
    logic saw_rsp;

    rst            = 1'b1;
    pl_en          = 1'b0;
    pl_idx         = 10'd0;
    pl_val         = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    preload(3, 32'h80001234);
    preload(4, 32'hDEADBEEF);
    preload(5, 32'h01020304);
    preload(8, 32'h11223344);
    preload(1023, 32'h7E7E7E7E);

    // Reset values.
    chk("ready_in_reset", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset mem_wd", bus.mem_wd, 32'd0);

    //       we    f3      addr          wdata         rdata         err  lat wr idx  val
    add_vec(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b000, 32'h10,       32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b100, 32'h11,       32'h0,        32'h000000BE, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b1, 3'b000, 32'h11,       32'h12345655, 32'h0,        1'b0, 3, 1,  4, 32'hDEAD55EF);
    add_vec(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEAD55EF, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b1, 3'b001, 32'h11,       32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b0, 3'b010, 32'h12,       32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b0, 3'b000, 32'h1000,     32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0,  4, 32'hDEAD55EF);
    add_vec(1'b0, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b1, 3'b111, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0);
    add_vec(1'b1, 3'b001, 32'h16,       32'h0000CAFE, 32'h0,        1'b0, 3, 1,  5, 32'hCAFE0304);
    add_vec(1'b1, 3'b000, 32'h17,       32'hFFFFFF99, 32'h0,        1'b0, 3, 1,  5, 32'h99FE0304);
    add_vec(1'b1, 3'b010, 32'h20,       32'h0BADF00D, 32'h0,        1'b0, 2, 1,  8, 32'h0BADF00D);
    add_vec(1'b0, 3'b010, 32'hFFC,      32'h0,        32'h7E7E7E7E, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b001, 32'h0E,       32'h0,        32'hFFFF8000, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b101, 32'h0E,       32'h0,        32'h00008000, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b001, 32'h0C,       32'h0,        32'h00001234, 1'b0, 2, 0, -1, 32'h0);
    add_vec(1'b0, 3'b000, 32'h0F,       32'h0,        32'hFFFFFF80, 1'b0, 2, 0, -1, 32'h0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef LSU_STAT_EN
    chk("stat_loads", {16'd0, stat_loads}, 32'(n_loads));
    chk("stat_stores", {16'd0, stat_stores}, 32'(n_stores));
    chk("stat_errs", {16'd0, stat_errs}, 32'(n_errs));
`endif

    // Reset lands in the WRITE cycle of sw 0x20: the write must be dropped.
    wait_ready("rstwr");
    w0 = we_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rstwr mem_a", bus.mem_a, 32'd8);
    chk("rstwr mem_wd", bus.mem_wd, 32'hA5A5A5A5);
    chk("rstwr mem_we_pre", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr mem_we_gated", {31'd0, bus.mem_we}, 32'd0);
    chk("rstwr ready_gated", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.rsp_valid === 1'b1) saw_rsp = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("rstwr no_rsp", {31'd0, saw_rsp}, 32'd0);
    chk("rstwr mem8", mem[8], 32'h0BADF00D);
    chk("rstwr writes", 32'(we_count - w0), 32'd0);
    chk("rstwr ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("rstwr mem_a_idle", bus.mem_a, 32'd0);

`ifdef LSU_STAT_EN
    chk("stat_loads_clr", {16'd0, stat_loads}, 32'd0);
    chk("stat_stores_clr", {16'd0, stat_stores}, 32'd0);
    chk("stat_errs_clr", {16'd0, stat_errs}, 32'd0);
`endif

    // Unit still works after the aborted store.
    n = 0;
    run_vec('{1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 2, 0, -1, 32'h0}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
